// File: rtl/pwm_sample_player_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sample_player_if
// Description : Valid/ready sample handshake into the PWM sample player.
// Revision    : 1.0  initial release
// ============================================================================
interface pwm_sample_player_if #(
    parameter int SAMPLE_W = 8
) ();
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_in, output sample_valid, input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface
`default_nettype wire

// File: rtl/pwm_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sample_player
// Description : FIFO-buffered PWM output stage, one sample per PWM period,
//               with a sticky underrun flag.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_sample_player #(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1,
    parameter bit SIGNED_IN  = 1'b1,
    parameter int IDLE_LEVEL = 128
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    pwm_sample_player_if.slave            sample_if,
    input  logic                          underrun_clr,
    output logic                          pwm_out,
    output logic                          period_strobe,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = c_addr_w + 1;
    localparam int c_pre_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [SAMPLE_W-1:0] c_idle    = SAMPLE_W'(IDLE_LEVEL);
    localparam logic [SAMPLE_W-1:0] c_cnt_max = '1;
    localparam logic [c_pre_w-1:0]  c_pre_max = c_pre_w'(PRESCALE - 1);
    localparam logic [c_lvl_w-1:0]  c_full    = c_lvl_w'(FIFO_DEPTH);

    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;
    logic [c_pre_w-1:0]  r_pre;
    logic [SAMPLE_W-1:0] r_cnt;
    logic [SAMPLE_W-1:0] r_duty;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_tick;
    logic                w_load;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_sample;

    // Signed input becomes offset binary by flipping the MSB.
    generate
        if (SIGNED_IN) begin : g_signed
            assign w_sample = {~sample_if.sample_in[SAMPLE_W-1], sample_if.sample_in[SAMPLE_W-2:0]};
        end else begin : g_unsigned
            assign w_sample = sample_if.sample_in;
        end
    endgenerate

    assign w_full                 = (r_level == c_full);
    assign w_empty                = (r_level == '0);
    assign sample_if.sample_ready = !w_full;
    assign w_push                 = sample_if.sample_valid && !w_full;
    assign w_tick                 = enable && (r_pre == c_pre_max);
    assign w_load                 = w_tick && (r_cnt == c_cnt_max);
    assign w_pop                  = w_load && !w_empty;
    assign fifo_level             = r_level;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            r_level <= r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
        end
    end

    // Counters park at zero while disabled so re-enabling starts a fresh period.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + c_pre_w'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + SAMPLE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_duty        <= c_idle;
            pwm_out       <= 1'b0;
            period_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            pwm_out       <= enable && (r_cnt < r_duty);
            period_strobe <= w_load;
            if (!enable) begin
                r_duty <= c_idle;
            end else if (w_pop) begin
                r_duty <= r_mem[r_rd_ptr];
            end
            // A load finding the FIFO empty outranks a same-cycle clear.
            if (w_load && w_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_sample_player
// Description : Randomized self-checking bench against a time-based model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_sample_player;

    localparam int c_pre   = 2;
    localparam int c_depth = 4;
    localparam int c_per   = c_pre * 256;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       underrun_clr = 1'b0;
    logic       pwm_out;
    logic       period_strobe;
    logic       underrun;
    logic [2:0] fifo_level;

    pwm_sample_player_if #(.SAMPLE_W(8)) sif ();

    pwm_sample_player #(
        .SAMPLE_W   (8),
        .FIFO_DEPTH (c_depth),
        .PRESCALE   (c_pre),
        .SIGNED_IN  (1'b1),
        .IDLE_LEVEL (128)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .sample_if     (sif.slave),
        .underrun_clr  (underrun_clr),
        .pwm_out       (pwm_out),
        .period_strobe (period_strobe),
        .underrun      (underrun),
        .fifo_level    (fifo_level)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: enabled time since (re)start determines position in period.
    logic [7:0] m_q[$];
    int         m_duty = 128;
    int         m_t    = 0;
    bit         m_ur   = 1'b0;
    bit         m_strobe = 1'b0;
    bit         m_pwm  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        bit push_ok;
        bit set_ur;
        int pos;
        @(posedge clock);
        push_ok = sif.sample_valid && (m_q.size() < c_depth);
        if (reset) begin
            m_q.delete();
            m_duty = 128; m_t = 0; m_ur = 0; m_strobe = 0; m_pwm = 0;
        end else begin
            set_ur = 0;
            if (enable) begin
                pos      = m_t % c_per;
                m_pwm    = ((pos / c_pre) < m_duty);
                m_strobe = (pos == c_per - 1);
                if (m_strobe) begin
                    if (m_q.size() > 0) m_duty = m_q.pop_front();
                    else                set_ur = 1;
                end
                m_t++;
            end else begin
                m_t = 0; m_duty = 128; m_pwm = 0; m_strobe = 0;
            end
            if (set_ur)            m_ur = 1;
            else if (underrun_clr) m_ur = 0;
            if (push_ok) m_q.push_back(sif.sample_in ^ 8'h80);
        end
        #1;
        check("pwm_out",       32'(pwm_out),       32'(m_pwm));
        check("period_strobe", 32'(period_strobe), 32'(m_strobe));
        check("underrun",      32'(underrun),      32'(m_ur));
        check("fifo_level",    32'(fifo_level),    32'(m_q.size()));
        check("sample_ready",  32'(sif.sample_ready), 32'(m_q.size() < c_depth));
    endtask

    initial begin
        int hi;
        int rate;
        int off_cnt;
        int r;
        sif.sample_valid = 1'b0;
        sif.sample_in    = 8'h00;

        repeat (2) step();
        reset = 1'b0;
        step();

        // One sample, then two periods: high 128 then 0xC0 ticks.
        sif.sample_valid = 1'b1; sif.sample_in = 8'h40;
        step();
        sif.sample_valid = 1'b0;
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < c_per; i++) begin step(); hi += int'(pwm_out); end
        check("high_period1", 32'(hi), 32'(128 * c_pre));
        hi = 0;
        for (int i = 0; i < c_per; i++) begin step(); hi += int'(pwm_out); end
        check("high_period2", 32'(hi), 32'(192 * c_pre));

        // Fill while disabled: fifth push refused.
        enable = 1'b0; underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sif.sample_valid = 1'b1; sif.sample_in = 8'(8'h10 + i);
            step();
        end
        sif.sample_valid = 1'b0;
        check("full_level", 32'(fifo_level), 32'd4);

        // Edge samples 0x80, 0x00, 0x7F -> duty 0, 128, 255.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sif.sample_valid = 1'b1;
            sif.sample_in = (i == 0) ? 8'h80 : (i == 1) ? 8'h00 : 8'h7F;
            step();
        end
        sif.sample_valid = 1'b0;
        enable = 1'b1;
        for (int p = 0; p < 4; p++) begin
            hi = 0;
            for (int i = 0; i < c_per; i++) begin step(); hi += int'(pwm_out); end
            check("high_edge", 32'(hi), 32'(((p == 0) ? 128 : (p == 1) ? 0 : (p == 2) ? 128 : 255) * c_pre));
        end

        // Randomized segments with different producer rates.
        off_cnt = 0;
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       rate = 150;
                1:       rate = 900;
                2:       rate = 300;
                default: rate = 2000;
            endcase
            for (int c = 0; c < 4500; c++) begin
                sif.sample_valid = ($urandom_range(rate - 1) == 0);
                r = $urandom_range(7);
                sif.sample_in = (r == 0) ? 8'h80 : (r == 1) ? 8'h7F : 8'($urandom);
                underrun_clr = ($urandom_range(399) == 0);
                reset        = ($urandom_range(9999) == 0);
                if (off_cnt > 0) begin
                    off_cnt--;
                    enable = (off_cnt == 0);
                end else if ($urandom_range(2999) == 0) begin
                    off_cnt = $urandom_range(20, 1);
                    enable  = 1'b0;
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
